// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

endpackage

// File: rtl/dmem_array.sv
// Byte-enable 32-bit word RAM: synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [WORD_BYTES-1:0]          be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write only the enabled byte lanes of the addressed word.
  // NOTE: the storage has no reset on purpose; contents survive reset and
  // a reset term would stop the array from mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states,
// registered response with address-error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0   // must be word aligned
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned WA = 32 - WORD_SHIFT;
  localparam logic [WA-1:0] BASE_W = BASE_ADDR[31:WORD_SHIFT];
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          accept, go_resp;
  logic          cur_we;
  logic [31:0]   cur_addr, cur_wdata;
  logic [3:0]    cur_be;
  logic [WA:0]   word_diff;
  logic          addr_err;
  logic [AW-1:0] word_idx;
  logic          arr_we;
  logic [31:0]   arr_rdata;

  // With zero wait states the response is formed on the accept edge, so the
  // live request must be used instead of the latched copy.
  always_comb begin
    cur_we    = (state_q == IDLE) ? req_we    : we_q;
    cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    cur_be    = (state_q == IDLE) ? req_be    : be_q;
    word_diff = {1'b0, cur_addr[31:WORD_SHIFT]} - {1'b0, BASE_W};
    addr_err  = (|cur_addr[WORD_SHIFT-1:0]) | word_diff[WA] | (|word_diff[WA-1:AW]);
    word_idx  = word_diff[AW-1:0];
    accept    = req_valid & req_ready;
    go_resp   = ((state_q == IDLE) & accept & (WAIT_STATES == 0)) |
                ((state_q == WAIT) & (cnt_q == WAIT_LAST));
    arr_we    = go_resp & cur_we & ~addr_err;
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (cur_be),
    .idx   (word_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == WAIT_LAST) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is forced low while reset is held.
  always_comb begin
    req_ready = (state_q == IDLE) & reset;
    rsp_valid = (state_q == RESP);
  end

  // Request latch, wait counter and response capture.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = '0;
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (go_resp) begin
      err_d   = addr_err ? ERR_ADDR : ERR_NONE;
      rdata_d = (cur_we | addr_err) ? 32'h0 : arr_rdata;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder with a word-map model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          WIN   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model_mem [int];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a);
    longint unsigned la = longint'(a);
    longint unsigned lo = longint'(BASE);
    longint unsigned hi = lo + 4 * longint'(DEPTH);
    return (a % 4 != 0) || (la < lo) || (la >= hi);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] window_addr(input int i);
    return BASE + 32'(4 * i);
  endfunction

  // One full transaction: present, accept, wait, optional backpressure with
  // an optional unaccepted request poked during it, then consume.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, input bit poke,
                      output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rdata, d0, tmp;
    logic        r0;
    int          spin, lat, w;
    e_err   = exp_err(addr);
    e_rdata = 32'h0;
    if (!we && !e_err) e_rdata = model_mem[word_of(addr)];

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    spin = 0;
    while (!req_ready && spin < 50) begin @(posedge clk); #1; spin++; end
    check("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'h0;

    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("latency", 32'(lat), 32'(WS + 1));
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_rdata", rsp_rdata, e_rdata);
    got = rsp_rdata;
    d0  = rsp_rdata;
    r0  = rsp_err;

    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
        req_addr  = window_addr($urandom_range(0, WIN - 1));
        req_wdata = $urandom;
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", rsp_rdata, d0);
      check("hold_err", 32'(rsp_err), 32'(r0));
    end
    req_valid = 1'b0;

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    if (we && !e_err) begin
      w   = word_of(addr);
      tmp = model_mem.exists(w) ? model_mem[w] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) tmp[8*i +: 8] = wdata[8*i +: 8];
      model_mem[w] = tmp;
    end
  endtask

  initial begin
    logic [31:0] got, addr;
    int          r;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'd1);

    // Give every word the bench touches a known value, including the top word.
    for (int i = 0; i < WIN; i++) xact(1'b1, window_addr(i), $urandom, 4'hF, 0, 1'b0, got);
    xact(1'b1, window_addr(DEPTH - 1), $urandom, 4'hF, 0, 1'b0, got);

    // Store then load.
    xact(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, got);
    xact(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, 1'b0, got);
    check("dir_deadbeef", got, 32'hDEADBEEF);

    // Byte lanes.
    xact(1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 0, 1'b0, got);
    xact(1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 1, 1'b0, got);
    xact(1'b0, BASE + 32'h20, 32'h0, 4'h0, 0, 1'b0, got);
    check("dir_lanes", got, 32'h11BB33DD);

    // Empty lane mask is a legal no-op.
    xact(1'b1, BASE + 32'h20, 32'h55555555, 4'b0000, 0, 1'b0, got);
    xact(1'b0, BASE + 32'h20, 32'h0, 4'h0, 0, 1'b0, got);
    check("dir_be_zero", got, 32'h11BB33DD);

    // Errors: misaligned load, store just past the top, word 0 untouched.
    xact(1'b0, BASE + 32'h22, 32'h0, 4'h0, 0, 1'b0, got);
    xact(1'b1, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 0, 1'b0, got);
    xact(1'b0, BASE, 32'h0, 4'h0, 0, 1'b0, got);
    xact(1'b0, window_addr(DEPTH - 1), 32'h0, 4'h0, 0, 1'b0, got);

    // Backpressure with an unaccepted request presented during it.
    xact(1'b0, BASE + 32'h10, 32'h0, 4'h0, 5, 1'b1, got);
    xact(1'b0, BASE + 32'h20, 32'h0, 4'h0, 0, 1'b0, got);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       addr = window_addr($urandom_range(0, WIN - 1));
      else if (r < 7)  addr = window_addr(DEPTH - 1);
      else if (r < 8)  addr = window_addr($urandom_range(0, WIN - 1)) + 32'($urandom_range(1, 3));
      else if (r < 9)  addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
      else             addr = {$urandom_range(1, 255), 24'h0} | 32'(4 * $urandom_range(0, 63));
      xact(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), ($urandom_range(0, 3) == 0), got);
    end

    // Reset during the wait state of a store.
    xact(1'b1, BASE + 32'h30, 32'hCAFEF00D, 4'hF, 0, 1'b0, got);
    xact(1'b0, BASE + 32'h30, 32'h0, 4'h0, 0, 1'b0, got);
    check("dir_pre_reset_load", got, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h30;
    req_wdata = 32'h0BADF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midop_in_wait", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("midop_req_ready", 32'(req_ready), 32'd0);
    check("midop_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midop_rsp_rdata", rsp_rdata, 32'h0);
    check("midop_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midop_held_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    #1;
    check("midop_release_ready", 32'(req_ready), 32'd1);
    xact(1'b0, BASE + 32'h30, 32'h0, 4'h0, 0, 1'b0, got);
    check("dir_store_dropped", got, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
